// File: rtl/regfile_pkg.sv
// Shared widths and types for the general-purpose register file.
package regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 16;
    localparam int RF_ADDR_W = 4;

    typedef logic [RF_DATA_W-1:0] rf_data_t;
    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage : regfile_pkg

// File: rtl/rf_read_port.sv
// One registered read port: select mux, write-through bypass and output register.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              rd_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] sel_i,
    input  logic [ADDR_W-1:0] wr_sel_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [DATA_W-1:0] regs_i [DEPTH],
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;

    // Next read value; a same-edge write to the selected register wins over storage.
    always_comb begin
        data_d = data_q;
        if (en_i && rd_i) begin
            if (wr_i && (sel_i == wr_sel_i)) begin
                data_d = wr_data_i;
            end else begin
                data_d = regs_i[sel_i];
            end
        end else begin
            data_d = data_q;
        end
    end

    // Output register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= {DATA_W{1'b0}};
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule : rf_read_port

// File: rtl/register_file_wr.sv
// 16x32 register file: one synchronous write port, two registered read ports.
module register_file_wr
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              EN,
    input  logic              WR,
    input  logic              RD,
    input  logic [DATA_W-1:0] Ip1,
    input  logic [ADDR_W-1:0] sel_i1,
    input  logic [ADDR_W-1:0] sel_o1,
    input  logic [ADDR_W-1:0] sel_o2,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2
);

    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Next storage state: only the selected register changes on an enabled write.
    always_comb begin
        mem_d = mem_q;
        if (EN && WR) begin
            mem_d[sel_i1] = Ip1;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage array with asynchronous clear.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    rf_read_port #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rd_port1 (
        .clk_i     (CLK),
        .rst_ni    (rst),
        .en_i      (EN),
        .rd_i      (RD),
        .wr_i      (WR),
        .sel_i     (sel_o1),
        .wr_sel_i  (sel_i1),
        .wr_data_i (Ip1),
        .regs_i    (mem_q),
        .data_o    (op1)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rd_port2 (
        .clk_i     (CLK),
        .rst_ni    (rst),
        .en_i      (EN),
        .rd_i      (RD),
        .wr_i      (WR),
        .sel_i     (sel_o2),
        .wr_sel_i  (sel_i1),
        .wr_data_i (Ip1),
        .regs_i    (mem_q),
        .data_o    (op2)
    );

endmodule : register_file_wr

// File: tb/tb_register_file_wr.sv
// Directed bench for register_file_wr with a behavioural reference model.
module tb_register_file_wr;
    import regfile_pkg::*;

    logic     CLK = 1'b0;
    logic     rst = 1'b1;
    logic     EN  = 1'b0;
    logic     WR  = 1'b0;
    logic     RD  = 1'b0;
    rf_data_t Ip1 = 32'h0;
    rf_addr_t sel_i1 = 4'h0;
    rf_addr_t sel_o1 = 4'h0;
    rf_addr_t sel_o2 = 4'h0;
    rf_data_t op1;
    rf_data_t op2;

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_on   = 1'b0;

    register_file_wr dut (
        .CLK    (CLK),
        .rst    (rst),
        .EN     (EN),
        .WR     (WR),
        .RD     (RD),
        .Ip1    (Ip1),
        .sel_i1 (sel_i1),
        .sel_o1 (sel_o1),
        .sel_o2 (sel_o2),
        .op1    (op1),
        .op2    (op2)
    );

    always #5 CLK = ~CLK;

    // Reference model: an array of registers plus the two output values.
    rf_data_t m_mem [16] = '{default: 32'h0};
    rf_data_t m_op1 = 32'h0;
    rf_data_t m_op2 = 32'h0;

    always @(posedge CLK or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) m_mem[i] <= 32'h0;
            m_op1 <= 32'h0;
            m_op2 <= 32'h0;
        end else if (EN) begin
            if (WR) m_mem[sel_i1] <= Ip1;
            if (RD) begin
                m_op1 <= (WR && sel_o1 == sel_i1) ? Ip1 : m_mem[sel_o1];
                m_op2 <= (WR && sel_o2 == sel_i1) ? Ip1 : m_mem[sel_o2];
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_on) begin
            n_checks++;
            if (op1 !== m_op1) begin
                n_fails++;
                $display("FAIL model_op1 t=%0t got=%08h exp=%08h", $time, op1, m_op1);
            end
            n_checks++;
            if (op2 !== m_op2) begin
                n_fails++;
                $display("FAIL model_op2 t=%0t got=%08h exp=%08h", $time, op2, m_op2);
            end
        end
    end

    task automatic check(input string name, input rf_data_t got, input rf_data_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%08h exp=%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic read_all_zero(input string name);
        EN = 1'b1; WR = 1'b0; RD = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sel_o1 = rf_addr_t'(i);
            sel_o2 = rf_addr_t'(15 - i);
            tick();
            check(name, op1, 32'h0);
            check(name, op2, 32'h0);
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        chk_on = 1'b1;
        EN = 1'b1; WR = 1'b1; RD = 1'b1; Ip1 = 32'hCAFEF00D;
        for (int k = 0; k < 10; k++) begin
            sel_i1 = rf_addr_t'($urandom_range(15));
            sel_o1 = rf_addr_t'($urandom_range(15));
            sel_o2 = rf_addr_t'($urandom_range(15));
            #10;
        end
        check("reset_op1", op1, 32'h0);
        check("reset_op2", op2, 32'h0);
        WR = 1'b0;
        @(posedge CLK); #1 rst = 1'b1;
        read_all_zero("post_reset_read");

        // Basic write then read
        EN = 1'b1; RD = 1'b0; WR = 1'b1;
        Ip1 = 32'hABCDEFAB; sel_i1 = 4'd0; tick();
        Ip1 = 32'h01234567; sel_i1 = 4'd1; tick();
        WR = 1'b0; RD = 1'b1; sel_o1 = 4'd0; sel_o2 = 4'd1; tick();
        check("basic_op1", op1, 32'hABCDEFAB);
        check("basic_op2", op2, 32'h01234567);

        // Enable gating of write and of read
        EN = 1'b0; WR = 1'b1; RD = 1'b0; Ip1 = 32'hDEADBEEF; sel_i1 = 4'd2; tick();
        WR = 1'b0; RD = 1'b1; sel_o1 = 4'd2; sel_o2 = 4'd2; tick();
        check("en0_hold_op1", op1, 32'hABCDEFAB);
        check("en0_hold_op2", op2, 32'h01234567);
        EN = 1'b1; tick();
        check("en0_no_write", op1, 32'h0);

        // Write-through on each port independently
        WR = 1'b1; RD = 1'b1; sel_i1 = 4'd5; sel_o1 = 4'd5; sel_o2 = 4'd1;
        Ip1 = 32'h5A5A5A5A; tick();
        check("wt_port1_op1", op1, 32'h5A5A5A5A);
        check("wt_port1_op2", op2, 32'h01234567);
        sel_i1 = 4'd3; sel_o1 = 4'd1; sel_o2 = 4'd3; Ip1 = 32'h33333333; tick();
        check("wt_port2_op1", op1, 32'h01234567);
        check("wt_port2_op2", op2, 32'h33333333);

        // Same select on both ports, then hold with RD low
        WR = 1'b0; RD = 1'b1; sel_o1 = 4'd0; sel_o2 = 4'd0; tick();
        check("same_sel_op1", op1, 32'hABCDEFAB);
        check("same_sel_op2", op2, 32'hABCDEFAB);
        RD = 1'b0; sel_o1 = 4'd5; sel_o2 = 4'd3; tick();
        check("rd0_hold_op1", op1, 32'hABCDEFAB);
        check("rd0_hold_op2", op2, 32'hABCDEFAB);
        RD = 1'b1; tick();
        check("storage_op1", op1, 32'h5A5A5A5A);
        check("storage_op2", op2, 32'h33333333);

        // Asynchronous reset between edges during a write
        WR = 1'b1; RD = 1'b1; Ip1 = 32'hFFFFFFFF; sel_i1 = 4'd7;
        sel_o1 = 4'd0; sel_o2 = 4'd7;
        #2 rst = 1'b0;
        #1;
        check("async_rst_op1", op1, 32'h0);
        check("async_rst_op2", op2, 32'h0);
        tick(); tick();
        WR = 1'b0;
        @(posedge CLK); #1 rst = 1'b1;
        read_all_zero("post_midrst_read");

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_register_file_wr
